// File: rtl/clint_axi_slave_pkg.sv
// Constants and helpers for the CLINT mtime AXI slave, shared with the SoC/CLINT crossbar.
package clint_axi_slave_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [31:0] CLINT_MTIME_LO_ADDR = 32'h1001_0000;
   localparam logic [31:0] CLINT_MTIME_HI_ADDR = 32'h1001_0004;

   typedef enum logic {R_IDLE, R_DATA} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wr_state_e;

   // Only single-beat, 32-bit, INCR accesses are served; everything else gets SLVERR.
   function automatic logic is_simple_access(input logic [7:0] len, input logic [2:0] size,
                                             input logic [1:0] burst);
      return (len == 8'd0) && (size == 3'b010) && (burst == 2'b01);
   endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Prescaled 64-bit mtime counter with a byte-masked 32-bit word write port.
module clint_mtime_counter #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic [63:0] mtime
);
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [63:0]   mtime_q, mtime_d, mtime_inc;
   logic [31:0]   word_sel, word_merged;
   logic          tick;

   // Unwritten bytes come from the incremented value, so a tick in the commit cycle is never lost.
   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign word_merged[gi*8 +: 8] = wstrb[gi] ? wdata[gi*8 +: 8] : word_sel[gi*8 +: 8];
   end

   always_comb begin
      tick      = (presc_q == PRESC_LAST);
      presc_d   = tick ? '0 : presc_q + PW'(1);
      mtime_inc = mtime_q + {63'd0, tick};
      word_sel  = wr_hi ? mtime_inc[63:32] : mtime_inc[31:0];
      mtime_d   = mtime_inc;
      if (wr_en) begin
         if (wr_hi) mtime_d[63:32] = word_merged;
         else       mtime_d[31:0]  = word_merged;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
         mtime_q <= '0;
      end else begin
         presc_q <= presc_d;
         mtime_q <= mtime_d;
      end
   end

   assign mtime = mtime_q;

endmodule

// File: rtl/clint_axi_slave.sv
// AXI4 slave exposing the CLINT mtime counter as two 32-bit words; independent read and write FSMs.
module clint_axi_slave
   import clint_axi_slave_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 1,
   parameter logic [31:0] BASE_ADDR = CLINT_MTIME_LO_ADDR
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic [3:0]  arid,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic [3:0]  rid,
   output logic        rlast,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awid,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   output logic [3:0]  bid,
   output logic [63:0] mtime
);
   logic unused_addr_bits;
   assign unused_addr_bits = ^{araddr[31:3], araddr[1:0], awaddr[31:3], awaddr[1:0], BASE_ADDR};

   rd_state_e   r_state_q, r_state_d;
   logic [3:0]  rid_q, rid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [7:0]  r_len_q, r_len_d, r_beat_q, r_beat_d;
   logic        ar_fire, r_fire;

   wr_state_e   w_state_q, w_state_d;
   logic        aw_done_q, aw_done_d, w_done_q, w_done_d, w_seen_q, w_seen_d;
   logic        aw_simple_q, aw_simple_d, aw_hi_q, aw_hi_d;
   logic [3:0]  awid_q, awid_d, wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        aw_fire, w_fire, commit, cur_simple, wr_en, wr_hi;
   logic [31:0] cur_wdata;
   logic [3:0]  cur_wstrb;

   assign arready = (r_state_q == R_IDLE);
   assign rvalid  = (r_state_q == R_DATA);
   assign rlast   = rvalid && (r_beat_q == r_len_q);
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign rid     = rid_q;
   assign ar_fire = arvalid && arready;
   assign r_fire  = rvalid && rready;

   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      r_len_d   = r_len_q;
      r_beat_d  = r_beat_q;
      case (r_state_q)
         R_IDLE: if (ar_fire) begin
            rid_d     = arid;
            r_len_d   = arlen;
            r_beat_d  = 8'd0;
            r_state_d = R_DATA;
            if (is_simple_access(arlen, arsize, arburst)) begin
               rdata_d = araddr[2] ? mtime[63:32] : mtime[31:0];
               rresp_d = RESP_OKAY;
            end else begin
               rdata_d = 32'd0;
               rresp_d = RESP_SLVERR;
            end
         end
         R_DATA: if (r_fire) begin
            if (rlast) r_state_d = R_IDLE;
            else       r_beat_d  = r_beat_q + 8'd1;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // wready is held low while reset is asserted so every output except the address readys reads 0.
   assign awready = (w_state_q != W_RESP) && !aw_done_q;
   assign wready  = reset && (w_state_q != W_RESP) && !w_done_q && !(w_seen_q && !aw_done_q);
   assign bvalid  = (w_state_q == W_RESP);
   assign bresp   = bresp_q;
   assign bid     = awid_q;
   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;

   always_comb begin
      w_state_d   = w_state_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      w_seen_d    = w_seen_q;
      aw_simple_d = aw_simple_q;
      aw_hi_d     = aw_hi_q;
      awid_d      = awid_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      bresp_d     = bresp_q;
      // Commit in the cycle the last of AW / final W arrives, using live channel values if they fire now.
      cur_simple  = aw_fire ? is_simple_access(awlen, awsize, awburst) : aw_simple_q;
      wr_hi       = aw_fire ? awaddr[2] : aw_hi_q;
      cur_wdata   = w_fire ? wdata : wdata_q;
      cur_wstrb   = w_fire ? wstrb : wstrb_q;
      commit      = (w_state_q != W_RESP) && (aw_done_q || aw_fire) && (w_done_q || (w_fire && wlast));
      wr_en       = commit && cur_simple;
      if (aw_fire) begin
         aw_done_d   = 1'b1;
         aw_simple_d = cur_simple;
         aw_hi_d     = awaddr[2];
         awid_d      = awid;
      end
      if (w_fire) begin
         w_seen_d = 1'b1;
         wdata_d  = wdata;
         wstrb_d  = wstrb;
         if (wlast) w_done_d = 1'b1;
      end
      case (w_state_q)
         W_IDLE, W_COLLECT: begin
            if (commit) begin
               w_state_d = W_RESP;
               bresp_d   = cur_simple ? RESP_OKAY : RESP_SLVERR;
            end else if (aw_fire || w_fire) begin
               w_state_d = W_COLLECT;
            end
         end
         W_RESP: if (bready) begin
            w_state_d = W_IDLE;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            w_seen_d  = 1'b0;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state_q   <= R_IDLE;
         rid_q       <= '0;
         rdata_q     <= '0;
         rresp_q     <= '0;
         r_len_q     <= '0;
         r_beat_q    <= '0;
         w_state_q   <= W_IDLE;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         w_seen_q    <= 1'b0;
         aw_simple_q <= 1'b0;
         aw_hi_q     <= 1'b0;
         awid_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         bresp_q     <= '0;
      end else begin
         r_state_q   <= r_state_d;
         rid_q       <= rid_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
         r_len_q     <= r_len_d;
         r_beat_q    <= r_beat_d;
         w_state_q   <= w_state_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         w_seen_q    <= w_seen_d;
         aw_simple_q <= aw_simple_d;
         aw_hi_q     <= aw_hi_d;
         awid_q      <= awid_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         bresp_q     <= bresp_d;
      end
   end

   clint_mtime_counter #(.TICK_DIV(TICK_DIV)) u_counter (
      .clock (clock),
      .reset (reset),
      .wr_en (wr_en),
      .wr_hi (wr_hi),
      .wdata (cur_wdata),
      .wstrb (cur_wstrb),
      .mtime (mtime)
   );

endmodule

// File: doc/clint_axi_slave.md
Name: clint_axi_slave

Overview:
- AXI4 slave implementing the CLINT machine timer.
- Sits directly downstream of the CLINT port of the SoC/CLINT crossbar.
- Holds a 64-bit free-running mtime counter, exposed as two 32-bit words at 0x1001_0000 (low) and 0x1001_0004 (high).
- Serves single-beat reads and writes; any other burst shape gets a SLVERR response of the correct length.

Parameters:
- TICK_DIV, 1, clock cycles per mtime increment (>=1); an internal prescaler counts 0..TICK_DIV-1.
- BASE_ADDR, 32'h1001_0000, base address; only addr[2] selects the word, other address bits are ignored.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- arvalid in 1; arready out 1; araddr in 32; arid in 4; arlen in 8; arsize in 3; arburst in 2  read address channel
- rvalid out 1; rready in 1; rdata out 32; rresp out 2; rid out 4; rlast out 1  read data channel
- awvalid in 1; awready out 1; awaddr in 32; awid in 4; awlen in 8; awsize in 3; awburst in 2  write address channel
- wvalid in 1; wready out 1; wdata in 32; wstrb in 4; wlast in 1  write data channel
- bvalid out 1; bready in 1; bresp out 2; bid out 4  write response channel
- mtime  out  64  live counter value, for the core's timer compare

Behaviour:
- Reset state (reset low, asynchronous): all outputs 0 except arready=1 and awready=1. mtime=0, prescaler=0, both FSMs in IDLE.
- Simple access: len==0, size==3'b010, burst==2'b01. OKAY=2'b00, SLVERR=2'b10.
- Prescaler:
  - Increments every cycle.
  - When it reaches TICK_DIV-1 it wraps to 0 and mtime increments by 1; 64-bit wrap from all-ones to 0 is silent.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On AR fire, latch arid, capture beat count arlen+1 and simple/not-simple.
  - Simple read: capture rdata from live mtime in the fire cycle (low word if araddr[2]==0, else high word).
  - Go to R_DATA with rvalid=1 on the next cycle, so AR-fire to rvalid latency is 1 cycle.
  - R_DATA: rid = latched id. Simple: rresp=OKAY, rlast=1. Non-simple: rdata=0, rresp=SLVERR, rlast=1 only on beat arlen+1.
  - rvalid, rdata, rresp and rlast stay stable until rready.
  - On R fire with rlast, return to R_IDLE; arready returns high the following cycle, so back-to-back reads take 2 cycles each.
- Write FSM, states W_IDLE, W_COLLECT and W_RESP:
  - AW and W are accepted independently in either order, including the same cycle.
  - awready=1 while no AW is latched; wready=1 while no final W beat is latched.
  - For a non-simple AW, keep accepting W beats (wready=1) until the wlast fire; data is discarded.
  - W beats that arrive before AW are held: at most one beat is latched and wready drops until AW arrives. A burst's remaining beats are then drained after AW.
  - Once AW and the final W are both latched, a simple write updates the selected word of mtime with per-byte wstrb masking in a single cycle. Then go to W_RESP with bvalid=1, bresp=OKAY, bid = latched awid.
  - Non-simple writes leave mtime unchanged and respond with SLVERR.
  - On B fire, go to W_IDLE; both readys are high the next cycle.
- Simultaneous events:
  - A write commit and a tick in the same cycle: the written bytes take the written value, the unwritten bytes take the incremented value. For a low-word write, the carry into the high word is computed from the pre-write low word. The prescaler is not reset by writes.
  - A read captures the pre-update value when it coincides with a write commit.
  - Read and write FSMs are fully independent.
- wstrb==0 on a simple write: no update, but still an OKAY response.
- Reset asserted mid-transaction: both FSMs return to IDLE immediately and any pending response is dropped; the master must also be reset.

Decomposition:
- Shared package: RESP_OKAY/RESP_SLVERR/RESP_DECERR, the CLINT low/high address constants, and the simple-access check as a function. These constants are shared with the crossbar.
- One sub-module, clint_mtime_counter: prescaler, 64-bit counter and byte-masked write merge. Inputs wr_en, wr_hi, wdata, wstrb; output mtime.
- AXI FSMs stay in the top level.

Test Plan:
- Read after reset, with TICK_DIV=1: AR at cycle 5 to address 0x1001_0000 -> rvalid at cycle 6, rdata=5 (±1 per the documented capture cycle), rresp=0, rlast=1, rid echoed.
- Write 0xFFFF_FFFF to the low word and 0x0000_0001 to the high word, then tick -> within 2 ticks the high word reads 0x2 and the low word wraps through 0, with a correct carry.
- Write with wstrb=4'b0010, wdata=0x0000_AB00 to the low word -> only byte 1 of the low word becomes 0xAB; the other bytes keep counting.
- W before AW: W issued 3 cycles early, then AW -> single commit, bvalid 1 cycle after AW fire, bid = awid.
- Read burst arlen=3 -> 4 beats with rresp=2'b10 and rdata=0, rlast only on beat 4. Write burst awlen=1 -> 2 W beats accepted, bresp=2'b10, mtime unaffected.
- Backpressure: hold rready/bready low for 10 cycles -> outputs stay stable. Assert reset mid-R_DATA -> rvalid=0 immediately, arready=1.
